// File: rtl/acia_seq.sv
// Polling sequencer for a 6850-style ACIA: master reset + config, then status polling,
// receive buffering and round-robin transmit from two requesters. `ACIA_SEQ_ERRCNT_EN enables err_cnt.
module acia_seq #(
    parameter logic [7:0] CTRL_WORD = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       acia_cs,
    output logic       acia_we,
    output logic       acia_rs,
    output logic [7:0] acia_din,
    input  logic [7:0] acia_dout,
    input  logic       tx0_valid,
    input  logic [7:0] tx0_data,
    output logic       tx0_ready,
    input  logic       tx1_valid,
    input  logic [7:0] tx1_data,
    output logic       tx1_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic [7:0] err_cnt,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        INIT_RST = 3'd0,
        INIT_CFG = 3'd1,
        POLL     = 3'd2,
        STAT     = 3'd3,
        RX_RD    = 3'd4,
        RX_CAP   = 3'd5,
        TX_WR    = 3'd6
    } state_t;

    state_t state, state_nxt;
    logic   armed;   // low for the first cycle after reset so no strobe leaves while rst_n is low
    logic   rr_ptr;  // 0: tx0 wins the next conflict, 1: tx1 wins
    logic   gnt0, gnt1;

    assign state_dbg = state;
    assign tx0_ready = gnt0;
    assign tx1_ready = gnt1;

    // Handshakes: a byte moves when valid & ready are both high at a rising clk edge; tx*_data
    // must hold while tx*_valid is high, and rx_valid/rx_data hold until that edge.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (armed && state == TX_WR) begin
            if (tx0_valid && tx1_valid) begin
                gnt0 = ~rr_ptr;
                gnt1 = rr_ptr;
            end else begin
                gnt0 = tx0_valid;
                gnt1 = tx1_valid;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        acia_cs   = 1'b0;
        acia_we   = 1'b0;
        acia_rs   = 1'b0;
        acia_din  = 8'h00;
        if (armed) begin
            case (state)
                INIT_RST: begin
                    acia_cs   = 1'b1;
                    acia_we   = 1'b1;
                    acia_din  = 8'h03;
                    state_nxt = INIT_CFG;
                end
                INIT_CFG: begin
                    acia_cs   = 1'b1;
                    acia_we   = 1'b1;
                    acia_din  = CTRL_WORD;
                    state_nxt = POLL;
                end
                POLL: begin
                    acia_cs   = 1'b1;
                    state_nxt = STAT;
                end
                STAT: begin
                    if (acia_dout[0] && !rx_valid)
                        state_nxt = RX_RD;
                    else if (acia_dout[1] && (tx0_valid || tx1_valid))
                        state_nxt = TX_WR;
                    else
                        state_nxt = POLL;
                end
                RX_RD: begin
                    acia_cs   = 1'b1;
                    acia_rs   = 1'b1;
                    state_nxt = RX_CAP;
                end
                RX_CAP: state_nxt = POLL;
                TX_WR: begin
                    // A requester that withdrew after STAT leaves this cycle without a strobe.
                    acia_cs   = gnt0 | gnt1;
                    acia_we   = gnt0 | gnt1;
                    acia_rs   = gnt0 | gnt1;
                    acia_din  = gnt1 ? tx1_data : (gnt0 ? tx0_data : 8'h00);
                    state_nxt = POLL;
                end
                default: state_nxt = INIT_RST;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT_RST;
            armed    <= 1'b0;
            rr_ptr   <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
        end else begin
            armed <= 1'b1;
            state <= state_nxt;
            if (gnt0 || gnt1)
                rr_ptr <= gnt0;
            if (state == RX_CAP) begin
                rx_valid <= 1'b1;
                rx_data  <= acia_dout;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef ACIA_SEQ_ERRCNT_EN
    logic       err_prev;
    logic [7:0] err_q;

    // Counts rising edges of the status error bit as seen across successive status samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_prev <= 1'b0;
            err_q    <= 8'h00;
        end else if (armed && state == STAT) begin
            err_prev <= acia_dout[4];
            if (acia_dout[4] && !err_prev && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_acia_seq.sv
// Bench for acia_seq: behavioural ACIA (byte queues, busy timer, status bits) plus
// randomized requesters/consumer, checked by rule against a scoreboard.
`timescale 1ns/1ps
module tb_acia_seq;

    localparam logic [7:0] CTRL = 8'h15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       acia_cs, acia_we, acia_rs;
    logic [7:0] acia_din;
    logic [7:0] acia_dout;
    logic       tx0_valid, tx1_valid, tx0_ready, tx1_ready;
    logic [7:0] tx0_data, tx1_data;
    logic       rx_valid, rx_ready;
    logic [7:0] rx_data, err_cnt;
    logic [2:0] state_dbg;

    acia_seq #(.CTRL_WORD(CTRL)) dut (
        .clk(clk), .rst_n(rst_n),
        .acia_cs(acia_cs), .acia_we(acia_we), .acia_rs(acia_rs),
        .acia_din(acia_din), .acia_dout(acia_dout),
        .tx0_valid(tx0_valid), .tx0_data(tx0_data), .tx0_ready(tx0_ready),
        .tx1_valid(tx1_valid), .tx1_data(tx1_data), .tx1_ready(tx1_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .err_cnt(err_cnt), .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ACIA + scoreboard state
    logic [7:0] line_q[$];      // bytes waiting inside the ACIA receiver
    logic [7:0] exp_q[$];       // bytes read from the ACIA, owed to the consumer
    logic [7:0] wr_log[$];      // bytes written to the ACIA transmit register
    logic [9:0] init_exp[3];
    bit         err_seq[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int         tx_busy, busy_max, ec_m, err_mode, poll_idx;
    int         init_step, init_cyc, cyc, rd_cnt, stage, exp_act, first_evt;
    int         tx_mode, rx_mode;
    bit         tx_ok, last_was_tx1, err_prev_m, st_rxf, st_txe, in_stat;
    bit         dout_load, acc0, acc1, line_push_en;
    logic [7:0] dout_next, last_rx;

    function automatic int exp_err();
`ifdef ACIA_SEQ_ERRCNT_EN
        return ec_m;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        exp_q.delete();
        stage = 0; init_step = 0; last_was_tx1 = 1'b1; tx_ok = 1'b0;
        err_prev_m = 1'b0; ec_m = 0; poll_idx = 0;
        dout_load = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
        acia_dout = 8'h00;
    endtask

    // Observe one cycle at the falling edge and play the ACIA's part.
    task automatic monitor();
        logic [7:0] b;
        logic [2:0] exp3;
        bit e;
        cyc++;
        dout_load = 1'b0; acc0 = 1'b0; acc1 = 1'b0; in_stat = 1'b0;
        if (tx_busy > 0) tx_busy--;
        if (rx_valid && rx_ready) begin
            check("rx_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                check("rx_data", rx_data, b);
                last_rx = rx_data;
            end
        end
        if (!(acia_cs && acia_we)) check("din_idle", acia_din, 8'h00);
        check("wr_needs_ready", acia_cs & acia_we & acia_rs, tx0_ready | tx1_ready);
        if (stage == 1) begin
            in_stat = 1'b1;
            check("stat_no_strobe", acia_cs, 0);
            if (st_rxf && !rx_valid) exp_act = 1;
            else if (st_txe && (tx0_valid || tx1_valid)) exp_act = 2;
            else exp_act = 0;
            stage = 2;
        end else if (stage == 2) begin
            if (exp_act == 1) exp3 = 3'b101;
            else if (exp_act == 2) exp3 = (tx0_valid || tx1_valid) ? 3'b111 : 3'b000;
            else exp3 = 3'b100;
            check("sched", {acia_cs, acia_we, acia_rs}, exp3);
            stage = 0;
        end
        if (acia_cs && init_step < 3) begin
            check("init_access", {acia_we, acia_rs, acia_din}, init_exp[init_step]);
            if (init_step > 0) check("init_consec", cyc - init_cyc, 1);
            init_cyc = cyc;
            init_step++;
        end else if (acia_cs) begin
            check("no_cfg_after_init", acia_we & ~acia_rs, 0);
        end
        if (tx0_ready || tx1_ready) begin
            check("rdy_onehot", tx0_ready & tx1_ready, 0);
            check("tx_allowed", tx_ok, 1);
            check("tx_rdy_valid", tx1_ready ? tx1_valid : tx0_valid, 1);
            if (tx0_valid && tx1_valid) check("rr_grant", tx0_ready, last_was_tx1);
            check("tx_din", acia_din, tx1_ready ? tx1_data : tx0_data);
            check("tx_strobe", {acia_cs, acia_we, acia_rs}, 3'b111);
            last_was_tx1 = tx1_ready;
            tx_ok = 1'b0;
            acc0 = tx0_ready; acc1 = tx1_ready;
            wr_log.push_back(acia_din);
            tx_busy = $urandom_range(0, busy_max);
            if (first_evt == 0) first_evt = 2;
        end
        if (acia_cs && !acia_we) begin
            dout_load = 1'b1;
            if (acia_rs) begin
                check("rd_buf_empty", rx_valid, 0);
                check("rd_line_byte", line_q.size() != 0, 1);
                dout_next = 8'h00;
                if (line_q.size() != 0) begin
                    dout_next = line_q.pop_front();
                    exp_q.push_back(dout_next);
                end
                rd_cnt++;
                if (first_evt == 0) first_evt = 1;
            end else begin
                if (err_mode == 0) e = ($urandom_range(0, 7) == 0);
                else if (err_mode == 1) e = err_seq[(poll_idx < 4) ? poll_idx : 4];
                else e = 1'b0;
                poll_idx++;
                if (e && !err_prev_m && ec_m < 255) ec_m++;
                err_prev_m = e;
                st_rxf = (line_q.size() != 0);
                st_txe = (tx_busy == 0);
                tx_ok = st_txe;
                dout_next = {3'b000, e, 2'b00, st_txe, st_rxf};
                stage = 1;
            end
        end
    endtask

    // Drive inputs just after the rising edge.
    task automatic apply();
        if (dout_load) acia_dout = dout_next;
        if (line_push_en && line_q.size() < 4 && $urandom_range(0, 7) == 0)
            line_q.push_back(8'($urandom));
        if (tx_mode == 1) begin
            if (acc0 || (tx0_valid && $urandom_range(0, 63) == 0)) tx0_valid = 1'b0;
            else if (!tx0_valid && $urandom_range(0, 3) == 0) begin
                tx0_valid = 1'b1; tx0_data = 8'($urandom);
            end
            if (acc1 || (tx1_valid && $urandom_range(0, 63) == 0)) tx1_valid = 1'b0;
            else if (!tx1_valid && $urandom_range(0, 3) == 0) begin
                tx1_valid = 1'b1; tx1_data = 8'($urandom);
            end
        end else if (tx_mode == 0) begin
            if (acc0) tx0_valid = 1'b0;
            if (acc1) tx1_valid = 1'b0;
        end
        if (rx_mode == 0) rx_ready = 1'($urandom_range(0, 1));
        else if (rx_mode == 1) rx_ready = 1'b0;
        else rx_ready = 1'b1;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            monitor();
            @(posedge clk);
            #1;
            apply();
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        check("rst_outs", {acia_cs, acia_we, acia_rs, acia_din, tx0_ready, tx1_ready, rx_valid, rx_data}, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_state", state_dbg, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply();
    endtask

    task automatic quiesce(input string tag);
        tx_mode = 0; tx0_valid = 1'b0; tx1_valid = 1'b0;
        line_push_en = 1'b0; rx_mode = 2; err_mode = 2;
        run_cycles(60);
        check({tag, "_init_done"}, init_step, 3);
        check({tag, "_exp_drained"}, exp_q.size(), 0);
        check({tag, "_line_drained"}, line_q.size(), 0);
        check({tag, "_err_cnt"}, err_cnt, exp_err());
    endtask

    initial begin
        bit found;
        logic [7:0] first, other;
        init_exp[0] = {1'b1, 1'b0, 8'h03};
        init_exp[1] = {1'b1, 1'b0, CTRL};
        init_exp[2] = {1'b0, 1'b0, 8'h00};
        acia_dout = 8'h00; tx0_valid = 1'b0; tx1_valid = 1'b0;
        tx0_data = 8'h00; tx1_data = 8'h00; rx_ready = 1'b0;
        tx_mode = 1; rx_mode = 0; line_push_en = 1'b1; busy_max = 6; err_mode = 0;
        cyc = 0; rd_cnt = 0; first_evt = 0; tx_busy = 0; last_rx = 8'h00;
        #2;
        reset_dut();
        run_cycles(10);
        check("init_seq_done", init_step, 3);

        // randomized traffic
        run_cycles(3000);
        quiesce("rand");

        // receive takes priority over a pending transmit
        busy_max = 0; wr_log.delete(); first_evt = 0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            monitor();
            found = in_stat;
            @(posedge clk);
            #1;
            apply();
        end
        check("stat_seen", found, 1);
        line_q.push_back(8'h5A);
        tx0_valid = 1'b1; tx0_data = 8'hA5;
        run_cycles(30);
        check("rx_before_tx", first_evt, 1);
        check("rx_byte_5a", last_rx, 8'h5A);
        check("tx_count", wr_log.size(), 1);
        if (wr_log.size() > 0) check("tx_byte_a5", wr_log[0], 8'hA5);

        // two continuous requesters alternate
        wr_log.delete();
        first = last_was_tx1 ? 8'h11 : 8'h22;
        other = last_was_tx1 ? 8'h22 : 8'h11;
        tx_mode = 2;
        tx0_valid = 1'b1; tx0_data = 8'h11; tx1_valid = 1'b1; tx1_data = 8'h22;
        for (int i = 0; i < 100 && wr_log.size() < 4; i++) run_cycles(1);
        check("alt_count", wr_log.size() >= 4, 1);
        for (int i = 0; i < 4; i++)
            if (i < wr_log.size()) check("alt_byte", wr_log[i], (i % 2 == 0) ? first : other);
        tx_mode = 0; tx0_valid = 1'b0; tx1_valid = 1'b0; busy_max = 6;
        run_cycles(10);

        // full receive buffer holds the ACIA off
        rx_mode = 1;
        run_cycles(10);
        rd_cnt = 0;
        for (int i = 0; i < 3; i++) line_q.push_back(8'($urandom));
        run_cycles(60);
        check("rx_hold_reads", rd_cnt, 1);
        check("rx_hold_valid", rx_valid, 1);
        rx_mode = 2;
        run_cycles(60);
        check("rx_drain_reads", rd_cnt, 3);
        check("rx_drain_exp", exp_q.size(), 0);

        // error-edge counting over a fixed status sequence
        err_mode = 1;
        reset_dut();
        run_cycles(60);
`ifdef ACIA_SEQ_ERRCNT_EN
        check("err_seq_cnt", err_cnt, 8'd2);
`else
        check("err_seq_cnt", err_cnt, 8'd0);
`endif

        // reset arriving during a transmit write
        err_mode = 0; tx_mode = 1; rx_mode = 0; line_push_en = 1'b1;
        run_cycles(200);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (tx0_ready || tx1_ready) found = 1'b1;
            else begin
                monitor();
                @(posedge clk);
                #1;
                apply();
            end
        end
        check("tx_wr_seen", found, 1);
        reset_dut();
        run_cycles(400);
        quiesce("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/acia_seq.md
ACIA_SEQ -- requirements
Module: acia_seq

Interface
REQ-001 Parameter CTRL_WORD, default 8'h00, ACIA control byte written after the ACIA master reset.
REQ-002 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port acia_cs  output  1  ACIA chip select, one-cycle strobe per access.
REQ-005 Port acia_we  output  1  ACIA write enable, valid with acia_cs.
REQ-006 Port acia_rs  output  1  ACIA register select: 0 = control/status, 1 = data.
REQ-007 Port acia_din  output  8  data written to the ACIA.
REQ-008 Port acia_dout  input  8  ACIA read data, valid the cycle after a read strobe.
REQ-009 Ports tx0_valid/tx1_valid  input  1 each  transmit requests from two requesters.
REQ-010 Ports tx0_data/tx1_data  input  8 each  transmit bytes, held stable while the matching valid is high.
REQ-011 Ports tx0_ready/tx1_ready  output  1 each  one-cycle accept pulse.
REQ-012 Port rx_valid  output  1  received byte available.
REQ-013 Port rx_data  output  8  received byte.
REQ-014 Port rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready.
REQ-015 Port err_cnt  output  8  receive-error event count.

Function
REQ-016 States: INIT_RST, INIT_CFG, POLL, STAT, RX_RD, RX_CAP, TX_WR.
REQ-017 INIT_RST: one-cycle write of 8'h03 to rs=0 (ACIA master reset); next INIT_CFG.
REQ-018 INIT_CFG: one-cycle write of CTRL_WORD to rs=0; next POLL.
REQ-019 POLL: read strobe, rs=0 (cs=1, we=0); next STAT.
REQ-020 STAT: sample acia_dout as status (bit0 rxf, bit1 txe, bit4 err); no strobe.
REQ-021 From STAT: if rxf=1 and rx buffer empty -> RX_RD; else if txe=1 and any tx valid -> TX_WR; else POLL.
REQ-022 RX has priority over TX whenever both qualify.
REQ-023 RX_RD: read strobe, rs=1 (clears ACIA rxf); next RX_CAP.
REQ-024 RX_CAP: load acia_dout into rx_data, set rx_valid; next POLL.
REQ-025 rx_valid stays high, rx_data stable, until the cycle after rx_valid & rx_ready.
REQ-026 Buffer full blocks RX_RD; the ACIA holds the byte; the sequencer does not drop or overwrite data.
REQ-027 TX_WR: write strobe, rs=1, acia_din = selected tx data; the selected tx*_ready pulses this cycle; next POLL.
REQ-028 TX arbitration is round-robin: on conflict, grant the requester not granted last; after reset, tx0 wins first.
REQ-029 A sole requester is granted regardless of round-robin pointer.
REQ-030 At most one ACIA strobe per cycle; acia_cs=0 in STAT; acia_din=8'h00 when not writing.
REQ-031 No second TX_WR before a STAT that shows txe=1.
REQ-032 tx_valid deasserted before grant is not served; no ready pulse is issued.

Reset
REQ-033 rst_n low: state=INIT_RST, acia_cs=0, acia_we=0, acia_rs=0, acia_din=0, tx0_ready=tx1_ready=0, rx_valid=0, rx_data=0, err_cnt=0, round-robin pointer=tx0.
REQ-034 Reset mid-transaction aborts it; buffered rx byte is discarded; sequence restarts at INIT_RST after release.

Configuration
REQ-035 Macro ACIA_SEQ_ERRCNT_EN defined: err_cnt increments on each STAT where err=1 and the previous STAT sample had err=0, saturating at 8'hFF.
REQ-036 Macro undefined: err_cnt is constant 8'h00; no counter logic.

Verification
REQ-037 Reset release, CTRL_WORD=8'h15 -> writes 8'h03 then 8'h15 on rs=0 in consecutive cycles, then status read strobe.
REQ-038 Status 8'h03, tx0_valid with 8'hA5 -> RX_RD/RX_CAP first, rx_data=acia data byte; TX_WR of 8'hA5 on a later poll.
REQ-039 tx0 and tx1 valid continuously (8'h11, 8'h22), txe=1 every poll -> written bytes alternate 11,22,11,22; ready pulses alternate.
REQ-040 rx_ready held low, rxf=1 persistent -> exactly one rx data read; no further rs=1 reads until rx_ready handshake.
REQ-041 With ACIA_SEQ_ERRCNT_EN, status err toggles 0,1,1,0,1 over five polls -> err_cnt=2; without macro err_cnt=0.
REQ-042 rst_n asserted during TX_WR -> all strobes low immediately, tx ready low, restart at INIT_RST.
